// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared constants and types for the audio PWM path
package sound_pkg;

  localparam int PWM_PERIOD = 1042;
  localparam int PWM_WIDTH  = 11;

  typedef enum logic [1:0] {
    WAIT_EDGE,
    MEAS,
    STUCK
  } pwm_dec_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with registered level and rising-edge strobe
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;

  // lvl doubles as the previous-level flop, so lvl and rise land on the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      lvl    <= 1'b0;
      rise   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      lvl    <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~lvl;
    end
  end

endmodule

// File: rtl/pwm_duty_decoder.sv
// rtl/pwm_duty_decoder.sv - recovers duty and period of a PWM waveform, flags stuck lines
module pwm_duty_decoder
  import sound_pkg::*;
#(
  parameter int PERIOD      = PWM_PERIOD,
  parameter int WIDTH       = PWM_WIDTH,
  parameter int TOL         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pwm_in,
  output logic [WIDTH-1:0]                 duty,
  output logic [$clog2(2*PERIOD+1)-1:0]    period_meas,
  output logic                             sample_valid,
  output logic                             period_ok,
  output logic                             stuck_low,
  output logic                             stuck_high
);

  localparam int            CW       = $clog2(2*PERIOD+1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(2*PERIOD);
  localparam logic [CW-1:0] PER_NOM  = CW'(PERIOD);
  localparam int            DUTY_MAX = (1 << WIDTH) - 1;

  pwm_dec_state_t   state;
  logic             lvl;
  logic             rise;
  logic [CW-1:0]    per_cnt;
  logic [CW-1:0]    hi_cnt;
  logic [WIDTH-1:0] duty_sat;
  logic [WIDTH-1:0] duty_stuck;
  logic             per_in_tol;
  logic             timeout;
  logic             do_sample;
  logic             do_stuck;
  int               per_diff;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pwm_in),
    .lvl  (lvl),
    .rise (rise)
  );

  // a rise in the timeout cycle wins, so timeout is masked by rise
  always_comb begin
    per_diff   = int'(per_cnt) - PERIOD;
    per_in_tol = (per_diff <= TOL) && (per_diff >= -TOL);
    duty_sat   = (int'(hi_cnt) > DUTY_MAX) ? WIDTH'(DUTY_MAX) : WIDTH'(hi_cnt);
    duty_stuck = lvl ? WIDTH'(PERIOD) : '0;
    timeout    = (per_cnt == CNT_MAX) && !rise;
    do_sample  = (state == MEAS) && rise;
    do_stuck   = (state != WAIT_EDGE) && timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_EDGE;
      per_cnt      <= '0;
      hi_cnt       <= '0;
      duty         <= '0;
      period_meas  <= '0;
      sample_valid <= 1'b0;
      period_ok    <= 1'b0;
      stuck_low    <= 1'b0;
      stuck_high   <= 1'b0;
    end else begin
      sample_valid <= do_sample || do_stuck;

      // a timeout restarts the count so stuck reports repeat every 2*PERIOD cycles
      if (rise || do_stuck) begin
        per_cnt <= CW'(1);
        hi_cnt  <= CW'(lvl);
      end else if (state != WAIT_EDGE) begin
        per_cnt <= (per_cnt == CNT_MAX) ? CNT_MAX : per_cnt + CW'(1);
        hi_cnt  <= (hi_cnt == CNT_MAX || !lvl) ? hi_cnt : hi_cnt + CW'(1);
      end

      if (do_sample) begin
        duty        <= duty_sat;
        period_meas <= per_cnt;
        period_ok   <= per_in_tol;
      end

      if (do_stuck) begin
        duty        <= duty_stuck;
        period_meas <= PER_NOM;
        period_ok   <= 1'b1;
        stuck_high  <= lvl;
        stuck_low   <= ~lvl;
      end else if (rise) begin
        stuck_high  <= 1'b0;
        stuck_low   <= 1'b0;
      end

      case (state)
        WAIT_EDGE: if (rise)     state <= MEAS;
        MEAS:      if (do_stuck) state <= STUCK;
        STUCK:     if (rise)     state <= MEAS;
        default:                 state <= WAIT_EDGE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb/tb_pwm_duty_decoder.sv - scoreboard bench for pwm_duty_decoder
module tb_pwm_duty_decoder;
  import sound_pkg::*;

  localparam int PER  = PWM_PERIOD;
  localparam int TOLC = 2;

  logic        clk;
  logic        rst;
  logic        pwm_in;
  logic [10:0] duty;
  logic [11:0] period_meas;
  logic        sample_valid;
  logic        period_ok;
  logic        stuck_low;
  logic        stuck_high;

  pwm_duty_decoder dut (
    .clk          (clk),
    .rst          (rst),
    .pwm_in       (pwm_in),
    .duty         (duty),
    .period_meas  (period_meas),
    .sample_valid (sample_valid),
    .period_ok    (period_ok),
    .stuck_low    (stuck_low),
    .stuck_high   (stuck_high)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int duty;
    int per;
    int ok;
    int slow;
    int shigh;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   m_state  = 0;
  int   m_rise   = 0;
  int   m_hi     = 0;
  int   m_next   = 0;
  bit   m_last   = 1'b0;
  logic prev_valid = 1'b0;
  int   thr_list[5] = '{0, 1, 521, 1041, 1042};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // model of the decoder: m_state 0 = waiting for first edge, 1 = measuring, 2 = stuck
  task automatic apply(input bit v);
    int c;
    int p;
    c = cyc;
    if (v && !m_last) begin
      if (m_state == 1) begin
        p = c - m_rise;
        q.push_back('{(m_hi > 2047) ? 2047 : m_hi, p,
                      ((p - PER <= TOLC) && (PER - p <= TOLC)) ? 1 : 0, 0, 0, c + 4});
      end
      m_state = 1;
      m_rise  = c;
      m_hi    = 0;
      m_next  = c + 4 + 2 * PER;
    end
    m_hi   += int'(v);
    m_last  = v;
    pwm_in  = v;
    if (m_state != 0 && c == m_next - 4) begin
      q.push_back('{v ? PER : 0, PER, 1, v ? 0 : 1, v ? 1 : 0, c + 4});
      m_state = 2;
      m_next += 2 * PER;
    end
  endtask

  task automatic drive(input bit v);
    @(negedge clk);
    apply(v);
  endtask

  task automatic hold(input bit v, input int n);
    for (int i = 0; i < n; i++) drive(v);
  endtask

  task automatic wave(input int h, input int p);
    for (int i = 0; i < p; i++) drive(i < h);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    while (q.size() > 0 && q[q.size()-1].cyc > cyc) void'(q.pop_back());
    m_state = 0;
    m_last  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_outputs", 32'({duty, period_meas, sample_valid, period_ok, stuck_low, stuck_high}), 32'd0);
    apply(pwm_in);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      check("missed_valid", 32'd0, 32'd1);
      void'(q.pop_front());
    end
    if (sample_valid === 1'b1) begin
      check("valid_width", 32'(prev_valid), 32'd0);
      if (q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("latency_cyc", cyc,                e.cyc);
        check("duty",        32'(duty),          e.duty);
        check("period_meas", 32'(period_meas),   e.per);
        check("period_ok",   32'(period_ok),     e.ok);
        check("stuck_low",   32'(stuck_low),     e.slow);
        check("stuck_high",  32'(stuck_high),    e.shigh);
      end
    end
    prev_valid = sample_valid;
  end

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_state", 32'({duty, period_meas, sample_valid, period_ok, stuck_low, stuck_high}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0);

    repeat (5) wave(521, PER);

    repeat (3) wave(300, PER);
    repeat (2) wave(900, PER);

    wave(521, PER);
    hold(1'b0, 3000);
    check("stuck_low_held", 32'(stuck_low), 32'd1);
    check("stuck_high_idle", 32'(stuck_high), 32'd0);
    hold(1'b0, 1500);
    wave(521, PER);
    check("stuck_low_cleared", 32'(stuck_low), 32'd0);
    wave(521, PER);

    hold(1'b1, 3000);
    check("stuck_high_held", 32'(stuck_high), 32'd1);
    check("stuck_low_idle", 32'(stuck_low), 32'd0);

    hold(1'b0, 50);
    repeat (2) wave(100, 1050);
    repeat (2) wave(100, 1044);
    check("stuck_high_cleared", 32'(stuck_high), 32'd0);

    wave(521, PER);
    hold(1'b1, 200);
    do_reset();
    hold(1'b1, 320);
    hold(1'b0, 521);
    repeat (2) wave(521, PER);

    for (int k = 0; k < 5; k++) repeat (3) wave(thr_list[k], PER);

    hold(1'b0, 10);
    do_reset();
    hold(1'b0, 10);
    check("queue_drained", q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
